// File: rtl/itcm_loader_pkg.sv
// Shared definitions for the ITCM boot loader: memory geometry, loader
// state encoding and header width.
// Ports: none (package only).
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 12
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif

package itcm_loader_pkg;

  localparam int ITCM_RAM_AW = `ITCM_RAM_AW;
  localparam int ITCM_RAM_DW = `ITCM_RAM_DW;
  localparam int HDR_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } ld_state_e;

  // Number of words in an ITCM of the given address width, widened so the
  // full-depth value is representable.
  function automatic logic [32:0] depth_words(input int aw);
    return 33'd1 << aw;
  endfunction

endpackage

// File: rtl/itcm_loader_byte_packer.sv
// Packs a byte stream into 32-bit little-endian words.
// Ports: clk/rst, clr (drop partial word), acc_i/byte_i (accepted byte),
//        word_vld_o (combinational, high with the 4th byte), word_o.
module itcm_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        acc_i,
  input  logic [7:0]  byte_i,
  output logic        word_vld_o,
  output logic [31:0] word_o
);

  logic [1:0]  bcnt_q;
  logic [23:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      bcnt_q <= 2'd0;
      sr_q   <= 24'd0;
    end else if (acc_i) begin
      bcnt_q <= bcnt_q + 2'd1;
      // The 4th byte bypasses the register straight into word_o.
      if (bcnt_q != 2'd3) begin
        sr_q[8*bcnt_q +: 8] <= byte_i;
      end
    end
  end

  assign word_vld_o = acc_i && (bcnt_q == 2'd3);
  assign word_o     = {byte_i, sr_q};

endmodule

// File: rtl/itcm_loader.sv
// Boot-time ITCM loader: takes a byte stream (32-bit LE word count, then
// LE words), writes the words to ITCM and holds the CPU until loaded.
// Ports: clk/rst, start, in_valid/in_data/in_ready byte stream,
//        itcm_ram_* write port, cpu_hold, busy/done/err status.
module itcm_loader
  import itcm_loader_pkg::*;
#(
  parameter int AW        = `ITCM_RAM_AW,
  parameter int DW        = ITCM_RAM_DW,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          itcm_ram_we,
  output logic [AW-1:0] itcm_ram_addr,
  output logic [DW-1:0] itcm_ram_din,
  output logic [3:0]    itcm_ram_wem,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  ld_state_e         state_q, state_d;
  logic [HDR_W-1:0]  n_q, n_d;
  logic [32:0]       widx_q, widx_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     din_q, din_d;

  logic              acc;
  logic              start_ok;
  logic              pk_vld;
  logic [31:0]       pk_word;

  assign in_ready = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign acc      = in_ready && in_valid;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));

  itcm_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_ok),
    .acc_i      (acc),
    .byte_i     (in_data),
    .word_vld_o (pk_vld),
    .word_o     (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      widx_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      widx_q  <= widx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    widx_d  = widx_q;
    we_d    = 1'b0;       // strobe is a single-cycle pulse per word
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_HDR;
          widx_d  = '0;
        end
      end
      ST_HDR: begin
        if (pk_vld) begin
          n_d    = pk_word;
          widx_d = '0;
          if (pk_word == '0) begin
            state_d = ST_DONE;
          end else if ({1'b0, pk_word} > depth_words(AW)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (pk_vld) begin
          we_d   = 1'b1;
          addr_d = widx_q[AW-1:0];
          din_d  = pk_word[DW-1:0];
          widx_d = widx_q + 33'd1;
          if (widx_q == ({1'b0, n_q} - 33'd1)) begin
            state_d = ST_FLUSH;
          end
        end
      end
      // The final write is on the port during this cycle; DONE (and CPU
      // release) follows only once it has been committed.
      ST_FLUSH: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign itcm_ram_we   = we_q;
  assign itcm_ram_addr = addr_q;
  assign itcm_ram_din  = din_q;
  assign itcm_ram_wem  = we_q ? 4'hF : 4'h0;

  assign busy = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                (state_q == ST_FLUSH);
  assign done = (state_q == ST_DONE);
  assign err  = (state_q == ST_ERR);

  always_comb begin
    unique case (state_q)
      ST_IDLE: cpu_hold = BOOT_HOLD;
      ST_DONE: cpu_hold = 1'b0;
      default: cpu_hold = 1'b1;
    endcase
  end

endmodule
